regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the pipelined CPU, replacing the fixed two-read, 32×32 register file. It sits in the ID stage and serves reads. WB-stage writes are forwarded into same-cycle reads, so the two edges no longer need separate phases. It adds a per-register pending scoreboard that tells hazard logic when an operand has an outstanding producer. It also keeps the JAL link-register write mode and hardwires register 0 to zero.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- LINK_REG, 31, destination forced by wr_link
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  combinational; the addressed register has a pending producer
- wr_en  in  1  write enable
- wr_link  in  1  write goes to LINK_REG instead of wr_addr
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- sb_set_en  in  1  mark a register pending (long-latency producer issued)
- sb_set_addr  in  ADDR_W  register to mark

## Operation
- Effective write address: weff = wr_link ? LINK_REG : wr_addr.
- Write: on a rising edge with rst_n=1, wr_en=1 and weff≠0, mem[weff] <= wr_data. Writes with weff=0 are discarded.
- Read, port i, on a rising edge with rd_en[i]=1:
  - rd_addr=0: rd_data_i <= 0.
  - Otherwise, if wr_en and weff==rd_addr: rd_data_i <= wr_data (write-first bypass).
  - Otherwise: rd_data_i <= mem[rd_addr].
- With rd_en[i]=0, rd_data_i holds its value.
- All ports are independent. Several ports may read the same address in the same cycle.
- Scoreboard: one pending bit sb[r] per register; sb[0] is constantly 0.
  - Rising edge with wr_en and weff≠0: sb[weff] <= 0.
  - Rising edge with sb_set_en and sb_set_addr≠0: sb[sb_set_addr] <= 1.
  - Set and clear on the same address in the same cycle: set wins, because the new producer is younger.
- rd_busy[i] = sb[rd_addr_i] & ~(wr_en & weff==rd_addr_i) & (rd_addr_i≠0). A register written in the current cycle is never reported busy.
- Reset (rst_n=0 at a rising edge) has priority over all other activity:
  - all mem entries cleared to 0;
  - all sb bits cleared;
  - all rd_data cleared to 0.
  - Writes, reads and sets presented in that cycle are ignored.
- Register contents are not loaded from a file. Test images are written via the write port after reset.

## Timing
- Read latency is 1 cycle: address at edge N gives rd_data valid after edge N.
- Write-to-read: data written at edge N is visible to a read sampled at edge N via the bypass. There is zero hazard distance.
- rd_busy is purely combinational from rd_addr, wr_* and sb. It has no internal register stage.
- Scoreboard set at edge N: rd_busy is asserted from edge N onward, until the clearing write's cycle.
- Reset takes one cycle. Operation is legal on the first edge after rst_n returns to 1.
- There are no #delays and no negedge logic.

## Structure
- Shared package `cpu_pkg`: DATA_W and ADDR_W defaults, LINK_REG constant, and a reg_addr_t typedef. The decoder and hazard unit use the same package.
- Sub-module `regfile_rd_port`, instantiated NUM_RD times through generate. Each instance holds:
  - the read mux,
  - the bypass compare,
  - the r0 zeroing,
  - the rd_busy term.
- Storage array, write logic and scoreboard stay in the top module.

## Test plan
- Reset, then read all 32 addresses on both ports → rd_data=0 for every address; rd_busy=0 everywhere.
- Write r5=0xDEADBEEF at edge N while port 0 reads r5 at edge N → rd_data0=0xDEADBEEF after edge N (bypass); port 1 reads r5 at N+1 → 0xDEADBEEF.
- wr_link=1, wr_addr=7, wr_data=0x00400010 → r31=0x00400010 and r7 unchanged (0). Write r0=0xFFFFFFFF → read r0 returns 0.
- sb_set r9 at N → rd_busy=1 for r9 during N+1..N+3. Write r9=0x12 at N+4 → rd_busy=0 in that cycle; rd_data=0x12.
- Same cycle: sb_set r9 and write r9=0x34 → r9=0x34 and sb[r9]=1 afterwards; rd_busy remains 1.
- Assert rst_n=0 mid-stream with a write r3=0x55 pending → after the edge, r3=0, all rd_data=0, all sb=0. NUM_RD=4 build: four simultaneous distinct reads return correct values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Used by the register file, decoder and hazard unit.
package cpu_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int LINK_REG_DEF = 31;
    localparam int NUM_RD_DEF   = 2;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: registered read mux, write-first bypass,
// r0 zeroing and the pending-producer busy flag.
module regfile_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int DEPTH = 2**ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_en_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] mem_i,
    input  logic [DEPTH-1:0]             sb_i,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic                         rd_busy_o
);

    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic              addr_nz;
    logic              hit;

    assign addr_nz = |rd_addr_i;
    assign hit     = wr_en_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            if (!addr_nz) begin
                rd_data_d = '0;
            end else if (hit) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = mem_i[rd_addr_i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

    // A write landing this cycle retires the producer, so it never reads busy.
    assign rd_busy_o = sb_i[rd_addr_i] & ~hit & addr_nz;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with write-first bypass, JAL link write,
// hardwired r0 and a per-register pending scoreboard.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic                     wr_link,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;
    logic [DEPTH-1:0]             sb_q;
    logic [DEPTH-1:0]             sb_d;
    logic [ADDR_W-1:0]            weff;
    logic                         wr_go;

    assign weff  = wr_link ? LINK_A : wr_addr;
    assign wr_go = wr_en && (weff != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_go) begin
            mem_d[weff] = wr_data;
        end
    end

    // Set after clear: a newly issued producer is younger than the writer.
    always_comb begin
        sb_d = sb_q;
        if (wr_go) begin
            sb_d[weff] = 1'b0;
        end
        if (sb_set_en && (sb_set_addr != '0)) begin
            sb_d[sb_set_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
            sb_q  <= '0;
        end else begin
            mem_q <= mem_d;
            sb_q  <= sb_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_en_i  (rd_en[i]),
            .rd_addr_i(rd_addr[i*ADDR_W +: ADDR_W]),
            .mem_i    (mem_q),
            .sb_i     (sb_q),
            .wr_en_i  (wr_en),
            .wr_addr_i(weff),
            .wr_data_i(wr_data),
            .rd_data_o(rd_data[i*DATA_W +: DATA_W]),
            .rd_busy_o(rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp built with four read ports.
module tb_regfile_mp;

    localparam int NRD = 4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   rd_en;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;
    logic [3:0]   rd_busy;
    logic         wr_en;
    logic         wr_link;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         sb_set_en;
    logic [4:0]   sb_set_addr;

    int total;
    int bad;

    regfile_mp #(
        .DATA_W(32),
        .ADDR_W(5),
        .NUM_RD(NRD),
        .LINK_REG(31)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_link    (wr_link),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sb_set_en  (sb_set_en),
        .sb_set_addr(sb_set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic         link;
        logic [4:0]   wa;
        logic [31:0]  wd;
        logic         se;
        logic [4:0]   sa;
        logic [3:0]   ren;
        logic [19:0]  ra;
        logic [3:0]   ebusy;
        logic [127:0] edata;
    } vec_t;

    function automatic vec_t mk(
        input logic we, input logic link, input logic [4:0] wa,
        input logic [31:0] wd, input logic se, input logic [4:0] sa,
        input logic [3:0] ren,
        input logic [4:0] a0, input logic [4:0] a1,
        input logic [4:0] a2, input logic [4:0] a3,
        input logic [3:0] eb,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic [31:0] d2, input logic [31:0] d3);
        vec_t v;
        v.we = we; v.link = link; v.wa = wa; v.wd = wd;
        v.se = se; v.sa = sa; v.ren = ren;
        v.ra = {a3, a2, a1, a0};
        v.ebusy = eb;
        v.edata = {d3, d2, d1, d0};
        return v;
    endfunction

    task automatic idle();
        wr_en = 0; wr_link = 0; wr_addr = 0; wr_data = 0;
        sb_set_en = 0; sb_set_addr = 0; rd_en = 0; rd_addr = 0;
    endtask

    task automatic chk_busy(input string nm, input logic [3:0] exp);
        total++;
        if (rd_busy !== exp) begin
            bad++;
            $display("FAIL %s busy: got %b exp %b", nm, rd_busy, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [127:0] exp);
        total++;
        if (rd_data !== exp) begin
            bad++;
            $display("FAIL %s data: got %h exp %h", nm, rd_data, exp);
        end
    endtask

    // Drive at posedge+1, check busy before the edge, data after it.
    task automatic apply(input string nm, input vec_t v);
        wr_en = v.we; wr_link = v.link; wr_addr = v.wa; wr_data = v.wd;
        sb_set_en = v.se; sb_set_addr = v.sa;
        rd_en = v.ren; rd_addr = v.ra;
        #1;
        chk_busy(nm, v.ebusy);
        @(posedge clk);
        #1;
        chk_data(nm, v.edata);
    endtask

    vec_t vt[18];

    initial begin
        total = 0;
        bad = 0;
        idle();
        rst_n = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;

        for (int a = 0; a < 32; a++) begin
            vec_t r;
            logic [4:0] ad;
            ad = 5'(a);
            r = mk(0,0,0,0, 0,0, 4'b1111, ad,ad,ad,ad, 4'b0000, 0,0,0,0);
            apply($sformatf("rst_r%0d", a), r);
        end

        vt[0]  = mk(1,0,5,32'hDEADBEEF, 0,0, 4'b0001, 5,0,0,0, 4'b0000,
                    32'hDEADBEEF,0,0,0);
        vt[1]  = mk(0,0,0,0, 0,0, 4'b0010, 0,5,0,0, 4'b0000,
                    32'hDEADBEEF,32'hDEADBEEF,0,0);
        vt[2]  = mk(1,1,7,32'h00400010, 0,0, 4'b1111, 31,7,5,0, 4'b0000,
                    32'h00400010,0,32'hDEADBEEF,0);
        vt[3]  = mk(1,0,0,32'hFFFFFFFF, 0,0, 4'b1111, 0,7,31,5, 4'b0000,
                    0,0,32'h00400010,32'hDEADBEEF);
        vt[4]  = mk(1,0,1,32'h11111111, 0,0, 4'b0000, 0,0,0,0, 4'b0000,
                    0,0,32'h00400010,32'hDEADBEEF);
        vt[5]  = mk(1,0,2,32'h22222222, 0,0, 4'b0001, 1,0,0,0, 4'b0000,
                    32'h11111111,0,32'h00400010,32'hDEADBEEF);
        vt[6]  = mk(1,0,3,32'h33333333, 0,0, 4'b1111, 1,2,3,5, 4'b0000,
                    32'h11111111,32'h22222222,32'h33333333,32'hDEADBEEF);
        vt[7]  = mk(0,0,0,0, 1,9, 4'b0001, 9,0,0,0, 4'b0000,
                    0,32'h22222222,32'h33333333,32'hDEADBEEF);
        vt[8]  = mk(0,0,0,0, 0,0, 4'b0000, 9,9,0,0, 4'b0011,
                    0,32'h22222222,32'h33333333,32'hDEADBEEF);
        vt[9]  = mk(0,0,0,0, 0,0, 4'b0000, 9,9,0,0, 4'b0011,
                    0,32'h22222222,32'h33333333,32'hDEADBEEF);
        vt[10] = mk(0,0,0,0, 0,0, 4'b0000, 9,9,0,0, 4'b0011,
                    0,32'h22222222,32'h33333333,32'hDEADBEEF);
        vt[11] = mk(1,0,9,32'h12, 0,0, 4'b0011, 9,9,0,0, 4'b0000,
                    32'h12,32'h12,32'h33333333,32'hDEADBEEF);
        vt[12] = mk(0,0,0,0, 0,0, 4'b0000, 9,0,0,0, 4'b0000,
                    32'h12,32'h12,32'h33333333,32'hDEADBEEF);
        vt[13] = mk(1,0,9,32'h34, 1,9, 4'b0001, 9,0,0,0, 4'b0000,
                    32'h34,32'h12,32'h33333333,32'hDEADBEEF);
        vt[14] = mk(0,0,0,0, 0,0, 4'b0001, 9,9,0,0, 4'b0011,
                    32'h34,32'h12,32'h33333333,32'hDEADBEEF);
        vt[15] = mk(1,0,9,32'h56, 0,0, 4'b0100, 9,9,9,0, 4'b0000,
                    32'h34,32'h12,32'h56,32'hDEADBEEF);
        vt[16] = mk(0,0,0,0, 1,11, 4'b0000, 11,11,0,0, 4'b0000,
                    32'h34,32'h12,32'h56,32'hDEADBEEF);
        vt[17] = mk(0,0,0,0, 0,0, 4'b0000, 11,9,0,11, 4'b1001,
                    32'h34,32'h12,32'h56,32'hDEADBEEF);

        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), vt[i]);
        end

        // Reset mid-stream with a write and a scoreboard set pending.
        wr_en = 1; wr_link = 0; wr_addr = 3; wr_data = 32'h55;
        sb_set_en = 1; sb_set_addr = 12;
        rd_en = 4'b1111; rd_addr = {5'd5, 5'd31, 5'd11, 5'd3};
        rst_n = 0;
        @(posedge clk);
        #1;
        chk_data("rst_mid", 128'h0);
        rst_n = 1;
        idle();
        rd_addr = {5'd5, 5'd3, 5'd12, 5'd11};
        #1;
        chk_busy("rst_sb", 4'b0000);
        rd_en = 4'b1111;
        rd_addr = {5'd1, 5'd5, 5'd31, 5'd3};
        @(posedge clk);
        #1;
        chk_data("rst_mem", 128'h0);

        // Four distinct simultaneous reads after a fresh image.
        apply("img_w4", mk(1,0,4,32'hA4A4A4A4, 0,0, 4'b0000, 0,0,0,0,
              4'b0000, 0,0,0,0));
        apply("img_w6", mk(1,0,6,32'hB6B6B6B6, 0,0, 4'b0000, 0,0,0,0,
              4'b0000, 0,0,0,0));
        apply("img_w8", mk(1,1,8,32'hC0FFEE31, 0,0, 4'b0000, 0,0,0,0,
              4'b0000, 0,0,0,0));
        apply("four_rd", mk(1,0,10,32'hD0D0D0D0, 0,0, 4'b1111, 4,6,31,10,
              4'b0000, 32'hA4A4A4A4,32'hB6B6B6B6,32'hC0FFEE31,32'hD0D0D0D0));
        apply("r8_untouched", mk(0,0,0,0, 0,0, 4'b0001, 8,0,0,0,
              4'b0000, 0,32'hB6B6B6B6,32'hC0FFEE31,32'hD0D0D0D0));

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
